// File: rtl/sfp_pkg.sv
// Shared types and constants for the sfp_accum post-array accumulation stage.
package sfp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACC,
        S_OUT,
        S_FIN
    } sfp_state_t;

    localparam int unsigned PASS_W = 4;

    function automatic int unsigned row_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [63:0] sat_hi(input int unsigned bw);
        return (64'd1 << (bw - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_lo(input int unsigned bw);
        return 64'd1 << (bw - 1);
    endfunction

endpackage

// File: rtl/sfp_accum_if.sv
// Handshake bundle for sfp_accum: output-FIFO pop side and finished-row stream side.
interface sfp_accum_if #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16
);
    logic                     ofifo_valid;
    logic                     ofifo_rd;
    logic [col*psum_bw-1:0]   ofifo_out;
    logic                     out_valid;
    logic                     out_ready;
    logic [col*psum_bw-1:0]   out_data;

    modport master (
        input  ofifo_valid, ofifo_out, out_ready,
        output ofifo_rd, out_valid, out_data
    );

    modport slave (
        output ofifo_valid, ofifo_out, out_ready,
        input  ofifo_rd, out_valid, out_data
    );
endinterface

// File: rtl/sfp_sat_add.sv
// One lane of signed saturating addition, result clamped to the psum_bw signed range.
module sfp_sat_add
    import sfp_pkg::*;
#(
    parameter int unsigned psum_bw = 16
) (
    input  logic [psum_bw-1:0] a,
    input  logic [psum_bw-1:0] b,
    output logic [psum_bw-1:0] y
);
    localparam logic [psum_bw-1:0] SAT_MAX = psum_bw'(sat_hi(psum_bw));
    localparam logic [psum_bw-1:0] SAT_MIN = psum_bw'(sat_lo(psum_bw));

    logic [psum_bw:0] sum;

    // Overflow shows as disagreement between the extended sign and the result sign.
    always_comb begin
        sum = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (sum[psum_bw] != sum[psum_bw-1]) begin
            y = sum[psum_bw] ? SAT_MIN : SAT_MAX;
        end else begin
            y = sum[psum_bw-1:0];
        end
    end
endmodule

// File: rtl/sfp_accum.sv
// Post-array accumulation: drains FIFO rows, sums them over n_pass passes, streams results.
// Build option: define SFP_RELU_EN to clamp negative output lanes to zero.
module sfp_accum
    import sfp_pkg::*;
#(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 16,
    parameter int unsigned rd_lat  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PASS_W-1:0]      n_pass,
    input  logic [$clog2(depth):0] n_row,
    sfp_accum_if.master            bus,
    output logic                   busy,
    output logic                   done
);
    localparam int unsigned DW     = col * psum_bw;
    localparam int unsigned ROW_W  = row_w(depth);
    localparam int unsigned IDX_W  = idx_w(depth);
    localparam int unsigned WCNT_W = (rd_lat > 1) ? $clog2(rd_lat) : 1;

    sfp_state_t        state;
    logic [PASS_W-1:0] p;
    logic [PASS_W-1:0] npass_q;
    logic [ROW_W-1:0]  r;
    logic [ROW_W-1:0]  nrow_q;
    logic [WCNT_W-1:0] wcnt;

    logic [DW-1:0]     buffer [depth];
    logic [DW-1:0]     sum_row;
    logic [DW-1:0]     out_row;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  out_idx;

    assign r_idx   = r[IDX_W-1:0];
    // While a row is on display, prefetch the next one so accepted rows stream back to back.
    assign out_idx = bus.out_valid ? r_idx + IDX_W'(1) : r_idx;

    for (genvar i = 0; i < col; i++) begin : g_lane
        sfp_sat_add #(.psum_bw(psum_bw)) u_add (
            .a (buffer[r_idx][i*psum_bw +: psum_bw]),
            .b (bus.ofifo_out[i*psum_bw +: psum_bw]),
            .y (sum_row[i*psum_bw +: psum_bw])
        );
    end

    always_comb begin
        out_row = buffer[out_idx];
`ifdef SFP_RELU_EN
        for (int unsigned i = 0; i < col; i++) begin
            if (out_row[i*psum_bw + psum_bw - 1]) begin
                out_row[i*psum_bw +: psum_bw] = '0;
            end
        end
`endif
    end

    // Buffer carries no reset; pass 0 always overwrites before any read.
    always_ff @(posedge clk) begin
        if (state == S_ACC) begin
            buffer[r_idx] <= (p == '0) ? bus.ofifo_out : sum_row;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            p             <= '0;
            r             <= '0;
            wcnt          <= '0;
            npass_q       <= '0;
            nrow_q        <= '0;
            bus.ofifo_rd  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            bus.ofifo_rd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        npass_q <= (n_pass == '0) ? PASS_W'(1) : n_pass;
                        nrow_q  <= (n_row == '0 || n_row > ROW_W'(depth)) ? ROW_W'(depth) : n_row;
                        p       <= '0;
                        r       <= '0;
                        busy    <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.ofifo_valid) begin
                        bus.ofifo_rd <= 1'b1;
                        wcnt         <= '0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt == WCNT_W'(rd_lat - 1)) begin
                        state <= S_ACC;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                S_ACC: begin
                    if (r == nrow_q - ROW_W'(1)) begin
                        r <= '0;
                        if (p == npass_q - PASS_W'(1)) begin
                            p     <= '0;
                            state <= S_OUT;
                        end else begin
                            p     <= p + PASS_W'(1);
                            state <= S_ISSUE;
                        end
                    end else begin
                        r     <= r + ROW_W'(1);
                        state <= S_ISSUE;
                    end
                end
                S_OUT: begin
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= out_row;
                    end else if (bus.out_ready) begin
                        if (r == nrow_q - ROW_W'(1)) begin
                            bus.out_valid <= 1'b0;
                            r             <= '0;
                            done          <= 1'b1;
                            state         <= S_FIN;
                        end else begin
                            r            <= r + ROW_W'(1);
                            bus.out_data <= out_row;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/sfp_accum.md
# sfp_accum

Post-array accumulation stage. Drains psum rows from the output FIFO, accumulates them across `n_pass` input-channel passes into a local row buffer with signed saturation, then streams the finished rows out on a valid/ready port. It sits between the output FIFO and the result SRAM writer.

## Interface
- `col`, default 8: lanes per row; matches the array column count.
- `psum_bw`, default 16: signed psum width per lane.
- `depth`, default 16: row-buffer capacity, in rows.
- `rd_lat`, default 2: cycles from `ofifo_rd` to valid data on `ofifo_out`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begin a job; sampled in IDLE only.
- `n_pass`  in  4  number of accumulation passes; 0 is treated as 1.
- `n_row`  in  $clog2(depth)+1  rows per pass; 0 or any value > depth is treated as `depth`.
- `ofifo_valid`  in  1  FIFO has a complete row (all columns non-empty).
- `ofifo_rd`  out  1  one-cycle pop request to the FIFO.
- `ofifo_out`  in  col*psum_bw  FIFO row data; lane i is at `[(i+1)*psum_bw-1 : i*psum_bw]`.
- `out_valid`  out  1  `out_data` holds a finished row.
- `out_ready`  in  1  downstream accepts the row.
- `out_data`  out  col*psum_bw  finished row.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the job completes.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACC, OUT, FIN.
- IDLE → ISSUE on `start`. Latch `n_pass` and `n_row`; clear the pass counter p and the row counter r.
- ISSUE: wait for `ofifo_valid`, then drive `ofifo_rd`=1 for exactly one cycle → WAIT.
- WAIT: count `rd_lat` cycles → ACC. No further `ofifo_rd` is issued; only one read is ever outstanding.
- ACC (1 cycle): capture `ofifo_out`.
  - p==0: buffer[r] = captured row (overwrite).
  - p>0: buffer[r] = buffer[r] + captured row, per lane.
  - Then increment r. On wrap (r == n_row-1), clear r and increment p.
  - Next state is OUT after the last row of the last pass, otherwise ISSUE.
- Per-lane arithmetic:
  - Signed psum_bw + psum_bw, computed at psum_bw+1 bits.
  - Result saturates to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - Example at psum_bw=16: 0x7FF0 + 0x0020 = 0x7FFF; 0x8000 + 0xFFFF = 0x8000.
- OUT: present buffer[r] for r = 0..n_row-1 in order.
  - `out_data` is registered and held stable while `out_valid` && !`out_ready`.
  - Advance on each `out_valid` && `out_ready`.
  - After the last row is accepted → FIN.
- FIN: `done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored.
- `ofifo_valid` dropping during ISSUE stalls the FSM in ISSUE; there is no timeout.

## Timing
- Reset values: `ofifo_rd`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0; FSM in IDLE; p=0, r=0.
- Reset asserted mid-job: aborts at once; the FSM returns to IDLE. Row-buffer contents are undefined after reset and are never read before being overwritten in pass 0.
- Drain throughput: one row per rd_lat+2 cycles (ISSUE, rd_lat×WAIT, ACC) when `ofifo_valid` is steady.
- Read spacing: `ofifo_rd` is never high on two cycles within rd_lat+2 cycles of each other. This gives the FIFO's registered read enable and empty flags time to settle.
- `out_valid` rises the cycle after entry to OUT. With `out_ready` held high, rows stream one per cycle.
- `done` is asserted the cycle after the final accept. `busy` falls in the same cycle that `done` falls.

## Configuration
- `SFP_RELU_EN` defined: each lane of `out_data` is forced to 0 when its sign bit is set. ReLU is applied at OUT only; the buffer keeps signed sums.
- `SFP_RELU_EN` not defined: `out_data` is the raw saturated sum.

## Structure
- Package `sfp_pkg`:
  - FSM state enum.
  - Saturation bound constants derived from `psum_bw`.
  - Counter widths for the pass and row counters.
- Sub-module `sfp_sat_add`: one lane of signed saturating add. It is instantiated `col` times in a generate loop.
- The row buffer is an inferred register array, depth × col*psum_bw.

## Test plan
- **Single pass.** n_pass=1, n_row=4; FIFO rows with lane i = i+r. Require: `out_data` rows exactly equal the inputs; `done` pulses once; `ofifo_rd` pulses exactly 4 times.
- **Three passes.** n_pass=3, n_row=2; every lane = 5 on each pass. Require: every output lane = 15.
- **Saturation.** n_pass=2, one lane with 0x7FF0 then 0x0020 → 0x7FFF; another lane with 0x8000 then 0xFFFF → 0x8000.
- **Backpressure and ReLU.** Hold `out_ready`=0 for 10 cycles mid-stream. Require: `out_data` stable and no row lost. With `SFP_RELU_EN` defined, a lane input of -3 outputs 0; without the macro, it outputs 0xFFFD.
- **Stall, abort and recovery.**
  - Drop `ofifo_valid` for 20 cycles: `ofifo_rd` stays 0 during the drop.
  - Pull `reset` low mid-job: all outputs reach their reset values asynchronously.
  - A fresh `start` then completes normally.
  - `start` pulsed while `busy`=1 is ignored.
